// File: rtl/tcp_con_mgr.sv
// TCP connection manager: drives connect/listen requests with timeout, backoff and retry limits.
// Every output is registered, so outputs lag their cause by one cycle. There is no backpressure; the engine status is sampled every cycle.
module tcp_con_mgr #(
   parameter int TICK_DIV              = 125000,
   parameter int CONNECT_TIMEOUT_TICKS = 1000,
   parameter int RETRY_BACKOFF_TICKS   = 500,
   parameter int MAX_RETRIES           = 0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        mode_server,
   input  logic [31:0] cfg_rem_ipv4,
   input  logic [15:0] cfg_rem_port,
   input  logic [15:0] cfg_loc_port,
   output logic        ctl_connect,
   output logic        ctl_listen,
   output logic [31:0] ctl_rem_ipv4,
   output logic [15:0] ctl_rem_port,
   output logic [15:0] ctl_loc_port,
   input  logic [2:0]  ctl_status,
   input  logic [31:0] ctl_con_ipv4,
   input  logic [15:0] ctl_con_port,
   output logic        up,
   output logic [31:0] peer_ipv4,
   output logic [15:0] peer_port,
   output logic [7:0]  retry_cnt,
   output logic        give_up
);

   localparam logic [2:0] TCP_CLOSED        = 3'd0;
   localparam logic [2:0] TCP_LISTENING     = 3'd1;
   localparam logic [2:0] TCP_CONNECTING    = 3'd2;
   localparam logic [2:0] TCP_CONNECTED     = 3'd3;
   localparam logic [2:0] TCP_DISCONNECTING = 3'd4;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WAIT_UP = 3'd1;
   localparam logic [2:0] S_UP      = 3'd2;
   localparam logic [2:0] S_BACKOFF = 3'd3;
   localparam logic [2:0] S_FAIL    = 3'd4;

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam logic [PW-1:0] PRESC_LAST  = PW'(TICK_DIV - 1);
   localparam logic [31:0]   TIMEOUT_T   = 32'(CONNECT_TIMEOUT_TICKS);
   localparam logic [31:0]   BACKOFF_T   = 32'(RETRY_BACKOFF_TICKS);
   localparam logic [7:0]    RETRY_LIMIT = 8'((MAX_RETRIES > 255) ? 255 : MAX_RETRIES);
   localparam bit            LIMITED     = (MAX_RETRIES != 0);

   logic [2:0]    state;
   logic          mode_srv;
   logic [PW-1:0] presc;
   logic [31:0]   timer;
   logic          tick;
   logic          connected;

   assign tick      = (presc == PRESC_LAST);
   assign connected = (ctl_status == TCP_CONNECTED);

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         mode_srv     <= 1'b0;
         presc        <= '0;
         timer        <= '0;
         ctl_connect  <= 1'b0;
         ctl_listen   <= 1'b0;
         ctl_rem_ipv4 <= '0;
         ctl_rem_port <= '0;
         ctl_loc_port <= '0;
         up           <= 1'b0;
         peer_ipv4    <= '0;
         peer_port    <= '0;
         retry_cnt    <= '0;
         give_up      <= 1'b0;
      end else begin
         presc <= tick ? '0 : presc + PW'(1);
         // Saturate so a huge timeout parameter never wraps the timer.
         if (tick && timer != '1)
            timer <= timer + 32'd1;

         if (!en) begin
            if (state != S_IDLE)
               timer <= '0;
            state       <= S_IDLE;
            ctl_connect <= 1'b0;
            ctl_listen  <= 1'b0;
            up          <= 1'b0;
            give_up     <= 1'b0;
            retry_cnt   <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  ctl_rem_ipv4 <= cfg_rem_ipv4;
                  ctl_rem_port <= cfg_rem_port;
                  ctl_loc_port <= cfg_loc_port;
                  mode_srv     <= mode_server;
                  ctl_connect  <= ~mode_server;
                  ctl_listen   <= mode_server;
                  timer        <= '0;
                  state        <= S_WAIT_UP;
               end
               S_WAIT_UP: begin
                  // A connect seen in the timeout cycle still counts as success.
                  if (connected) begin
                     up        <= 1'b1;
                     peer_ipv4 <= ctl_con_ipv4;
                     peer_port <= ctl_con_port;
                     retry_cnt <= '0;
                     timer     <= '0;
                     state     <= S_UP;
                  end else if (!mode_srv && timer == TIMEOUT_T) begin
                     ctl_connect <= 1'b0;
                     if (retry_cnt != 8'hff)
                        retry_cnt <= retry_cnt + 8'd1;
                     timer <= '0;
                     state <= S_BACKOFF;
                  end
               end
               S_UP: begin
                  if (!connected) begin
                     ctl_connect <= 1'b0;
                     ctl_listen  <= 1'b0;
                     up          <= 1'b0;
                     timer       <= '0;
                     state       <= S_BACKOFF;
                  end
               end
               S_BACKOFF: begin
                  // Wait out the backoff and for the engine to be fully closed.
                  if (timer >= BACKOFF_T && ctl_status == TCP_CLOSED) begin
                     timer <= '0;
                     if (LIMITED && retry_cnt >= RETRY_LIMIT) begin
                        give_up <= 1'b1;
                        state   <= S_FAIL;
                     end else begin
                        ctl_connect <= ~mode_srv;
                        ctl_listen  <= mode_srv;
                        state       <= S_WAIT_UP;
                     end
                  end
               end
               S_FAIL: begin
                  give_up <= 1'b1;
               end
               default: begin
                  ctl_connect <= 1'b0;
                  ctl_listen  <= 1'b0;
                  up          <= 1'b0;
                  timer       <= '0;
                  state       <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tcp_con_mgr.sv
// Directed bench for tcp_con_mgr with a small prescaler model used to hit exact timer cycles.
module tb_tcp_con_mgr;

   localparam logic [2:0] TCP_CLOSED        = 3'd0;
   localparam logic [2:0] TCP_CONNECTED     = 3'd3;
   localparam logic [2:0] TCP_DISCONNECTING = 3'd4;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        mode_server;
   logic [31:0] cfg_rem_ipv4;
   logic [15:0] cfg_rem_port;
   logic [15:0] cfg_loc_port;
   logic        ctl_connect;
   logic        ctl_listen;
   logic [31:0] ctl_rem_ipv4;
   logic [15:0] ctl_rem_port;
   logic [15:0] ctl_loc_port;
   logic [2:0]  ctl_status;
   logic [31:0] ctl_con_ipv4;
   logic [15:0] ctl_con_port;
   logic        up;
   logic [31:0] peer_ipv4;
   logic [15:0] peer_port;
   logic [7:0]  retry_cnt;
   logic        give_up;

   int n_vec = 0;
   int n_err = 0;
   int presc_m;

   tcp_con_mgr #(
      .TICK_DIV(4),
      .CONNECT_TIMEOUT_TICKS(10),
      .RETRY_BACKOFF_TICKS(5),
      .MAX_RETRIES(2)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .mode_server(mode_server),
      .cfg_rem_ipv4(cfg_rem_ipv4), .cfg_rem_port(cfg_rem_port), .cfg_loc_port(cfg_loc_port),
      .ctl_connect(ctl_connect), .ctl_listen(ctl_listen),
      .ctl_rem_ipv4(ctl_rem_ipv4), .ctl_rem_port(ctl_rem_port), .ctl_loc_port(ctl_loc_port),
      .ctl_status(ctl_status), .ctl_con_ipv4(ctl_con_ipv4), .ctl_con_port(ctl_con_port),
      .up(up), .peer_ipv4(peer_ipv4), .peer_port(peer_port),
      .retry_cnt(retry_cnt), .give_up(give_up)
   );

   always #5 clk = ~clk;

   // Free-running prescaler reference: 0..3, cleared only by reset.
   always @(posedge clk) begin
      if (rst) presc_m <= 0;
      else     presc_m <= (presc_m == 3) ? 0 : presc_m + 1;
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at the negedge just after a state-entry edge; returns at the
   // negedge of the cycle in which the DUT timer equals n.
   task automatic wait_timer(input string tag, input int n);
      int t = 0;
      int guard = 0;
      while (t != n && guard < 200) begin
         if (presc_m == 3) t++;
         @(negedge clk);
         guard++;
      end
      check_val({tag, "_tmr"}, 32'(t), 32'(n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; en = 1'b0; mode_server = 1'b0;
      cfg_rem_ipv4 = 32'hc0a8010a; cfg_rem_port = 16'd1000; cfg_loc_port = 16'd2000;
      ctl_status = TCP_CLOSED; ctl_con_ipv4 = 32'h0a000001; ctl_con_port = 16'd4321;
      repeat (3) @(negedge clk);
      check_val("rst_connect", ctl_connect, 0);
      check_val("rst_listen",  ctl_listen, 0);
      check_val("rst_up",      up, 0);
      check_val("rst_give_up", give_up, 0);
      check_val("rst_retry",   retry_cnt, 0);
      check_val("rst_rem_ip",  ctl_rem_ipv4, 0);
      rst = 1'b0;
      @(negedge clk);

      // Client connects
      en = 1'b1;
      @(negedge clk);
      check_val("c1_connect", ctl_connect, 1);
      check_val("c1_listen",  ctl_listen, 0);
      check_val("c1_rem_ip",  ctl_rem_ipv4, 32'hc0a8010a);
      check_val("c1_rem_port", ctl_rem_port, 16'd1000);
      check_val("c1_loc_port", ctl_loc_port, 16'd2000);
      repeat (18) @(negedge clk);
      check_val("c1_not_up", up, 0);
      ctl_status = TCP_CONNECTED;
      @(negedge clk);
      check_val("c1_up",        up, 1);
      check_val("c1_peer_ip",   peer_ipv4, 32'h0a000001);
      check_val("c1_peer_port", peer_port, 16'd4321);
      check_val("c1_retry",     retry_cnt, 0);
      check_val("c1_hold_conn", ctl_connect, 1);

      // Config change while up must not reach ctl_*
      cfg_rem_ipv4 = 32'h01020304; cfg_rem_port = 16'd7; cfg_loc_port = 16'd8;
      mode_server = 1'b1;
      repeat (2) @(negedge clk);
      check_val("cfg_chg_ip",   ctl_rem_ipv4, 32'hc0a8010a);
      check_val("cfg_chg_loc",  ctl_loc_port, 16'd2000);
      check_val("cfg_chg_lsn",  ctl_listen, 0);

      // en=0 mid-UP
      ctl_con_ipv4 = 32'hdeadbeef; ctl_con_port = 16'd1;
      en = 1'b0;
      @(negedge clk);
      check_val("dis_up",      up, 0);
      check_val("dis_connect", ctl_connect, 0);
      check_val("dis_peer_ip", peer_ipv4, 32'h0a000001);
      check_val("dis_peer_pt", peer_port, 16'd4321);
      ctl_status = TCP_CLOSED;

      // Client timeout, backoff, retry, give up
      mode_server = 1'b0;
      cfg_rem_ipv4 = 32'h0a0a0a0a; cfg_rem_port = 16'd555; cfg_loc_port = 16'd666;
      en = 1'b1;
      @(negedge clk);
      check_val("t2_connect", ctl_connect, 1);
      check_val("t2_rem_ip",  ctl_rem_ipv4, 32'h0a0a0a0a);
      wait_timer("t2_to1", 10);
      check_val("t2_to1_hold", ctl_connect, 1);
      @(negedge clk);
      check_val("t2_to1_drop", ctl_connect, 0);
      check_val("t2_to1_retry", retry_cnt, 1);
      wait_timer("t2_bo1", 5);
      check_val("t2_bo1_hold", ctl_connect, 0);
      @(negedge clk);
      check_val("t2_rearm", ctl_connect, 1);
      check_val("t2_rearm_ip", ctl_rem_ipv4, 32'h0a0a0a0a);
      wait_timer("t2_to2", 10);
      @(negedge clk);
      check_val("t2_to2_drop", ctl_connect, 0);
      check_val("t2_to2_retry", retry_cnt, 2);
      check_val("t2_to2_gu", give_up, 0);
      wait_timer("t2_bo2", 5);
      @(negedge clk);
      check_val("t2_give_up", give_up, 1);
      check_val("t2_fail_conn", ctl_connect, 0);
      check_val("t2_fail_retry", retry_cnt, 2);
      repeat (30) @(negedge clk);
      check_val("t2_fail_sticky", give_up, 1);
      check_val("t2_fail_stay0", ctl_connect, 0);
      en = 1'b0;
      @(negedge clk);
      check_val("t2_clr_gu", give_up, 0);
      check_val("t2_clr_retry", retry_cnt, 0);

      // Server: listen, drop, backoff waits for closed
      mode_server = 1'b1; cfg_loc_port = 16'd80;
      en = 1'b1;
      @(negedge clk);
      check_val("s_listen", ctl_listen, 1);
      check_val("s_connect", ctl_connect, 0);
      check_val("s_loc", ctl_loc_port, 16'd80);
      repeat (60) @(negedge clk);
      check_val("s_no_timeout", ctl_listen, 1);
      ctl_con_ipv4 = 32'h0b0c0d0e; ctl_con_port = 16'd9999;
      ctl_status = TCP_CONNECTED;
      @(negedge clk);
      check_val("s_up", up, 1);
      check_val("s_peer_ip", peer_ipv4, 32'h0b0c0d0e);
      ctl_status = TCP_DISCONNECTING;
      @(negedge clk);
      check_val("s_drop_up", up, 0);
      check_val("s_drop_lsn", ctl_listen, 0);
      check_val("s_drop_retry", retry_cnt, 0);
      wait_timer("s_bo", 5);
      repeat (6) @(negedge clk);
      check_val("s_bo_hold", ctl_listen, 0);
      ctl_status = TCP_CLOSED;
      @(negedge clk);
      check_val("s_rearm", ctl_listen, 1);
      check_val("s_rearm_conn", ctl_connect, 0);
      check_val("s_rearm_retry", retry_cnt, 0);
      en = 1'b0;
      @(negedge clk);

      // Connected in the same cycle the timeout is reached
      mode_server = 1'b0;
      en = 1'b1;
      @(negedge clk);
      wait_timer("sim", 10);
      ctl_status = TCP_CONNECTED;
      @(negedge clk);
      check_val("sim_up", up, 1);
      check_val("sim_conn", ctl_connect, 1);
      check_val("sim_retry", retry_cnt, 0);

      // Reset mid-WAIT_UP, then re-enable with new config
      ctl_status = TCP_CLOSED; en = 1'b0;
      @(negedge clk);
      en = 1'b1;
      @(negedge clk);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_val("r_connect", ctl_connect, 0);
      check_val("r_peer_ip", peer_ipv4, 0);
      check_val("r_rem_ip",  ctl_rem_ipv4, 0);
      cfg_rem_ipv4 = 32'h55667788; cfg_rem_port = 16'd1234; cfg_loc_port = 16'd4321;
      rst = 1'b0;
      @(negedge clk);
      check_val("r_reen_conn", ctl_connect, 1);
      check_val("r_reen_ip",   ctl_rem_ipv4, 32'h55667788);
      check_val("r_reen_port", ctl_rem_port, 16'd1234);
      check_val("r_reen_loc",  ctl_loc_port, 16'd4321);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
